// File: rtl/sdram_load_bridge.sv
// rtl/sdram_load_bridge.sv - buffers loader word writes into SDRAM over Avalon-MM, then serves playback reads
module sdram_load_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_op_begun,
    input  logic              in_init_done,
    input  logic              in_init_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [1:0]        avm_byteenable,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic              play_req,
    input  logic [ADDR_W-1:0] play_addr,
    output logic [DATA_W-1:0] play_data,
    output logic              play_valid,
    output logic              play_busy,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W-1:0] words_written
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [2:0] {
        LOAD,
        DRAIN,
        READY,
        RD_CMD,
        RD_WAIT,
        ERROR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              wr_active;
    logic              err_pending;
    logic [ADDR_W-1:0] rd_addr;

    // The extra pointer bit distinguishes a full ring from an empty one
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    // Next-state selection and all command/status outputs derived from the current state
    always_comb begin
        state_nxt      = state;
        in_op_begun    = 1'b0;
        wr_active      = 1'b0;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        avm_byteenable = 2'b00;
        play_busy      = 1'b1;
        load_done      = 1'b0;
        load_error     = 1'b0;

        in_op_begun = in_we && !full && (state == LOAD);

        // In ERROR only the write that was already on the bus may finish
        wr_active = (state == LOAD) || (state == DRAIN) ||
                    ((state == ERROR) && err_pending);
        avm_write = wr_active && !empty;
        avm_read  = (state == RD_CMD);

        if (avm_write) begin
            avm_address   = fifo_addr[rd_ptr[IDX_W-1:0]];
            avm_writedata = fifo_data[rd_ptr[IDX_W-1:0]];
        end else if (avm_read) begin
            avm_address = rd_addr;
        end
        if (avm_write || avm_read) begin
            avm_byteenable = 2'b11;
        end

        play_busy  = (state != READY);
        load_done  = (state == READY) || (state == RD_CMD) || (state == RD_WAIT);
        load_error = (state == ERROR);

        case (state)
            LOAD: begin
                if (in_init_error) begin
                    state_nxt = ERROR;
                end else if (in_init_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (in_init_error) begin
                    state_nxt = ERROR;
                end else if (empty) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (play_req) begin
                    state_nxt = RD_CMD;
                end
            end
            RD_CMD: begin
                if (!avm_waitrequest) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    state_nxt = READY;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    assign push = in_op_begun;
    assign pop  = avm_write && !avm_waitrequest;

    // State register
    always_ff @(posedge clk50) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk50) begin
        if (push) begin
            fifo_addr[wr_ptr[IDX_W-1:0]] <= in_address;
            fifo_data[wr_ptr[IDX_W-1:0]] <= in_data;
        end
    end

    // Buffer pointers and completed-write counter
    always_ff @(posedge clk50) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            words_written <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                words_written <= words_written + ADDR_W'(1);
            end
        end
    end

    // Remember whether a stalled write was on the bus when the error hit
    always_ff @(posedge clk50) begin
        if (reset) begin
            err_pending <= 1'b0;
        end else if ((state != ERROR) && (state_nxt == ERROR)) begin
            err_pending <= avm_write && avm_waitrequest;
        end else if (pop) begin
            err_pending <= 1'b0;
        end
    end

    // Playback read address capture and returned-sample register
    always_ff @(posedge clk50) begin
        if (reset) begin
            rd_addr    <= '0;
            play_data  <= '0;
            play_valid <= 1'b0;
        end else begin
            play_valid <= 1'b0;
            if ((state == READY) && play_req) begin
                rd_addr <= play_addr;
            end
            if ((state == RD_WAIT) && avm_readdatavalid) begin
                play_data  <= avm_readdata;
                play_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_load_bridge.sv
// tb/tb_sdram_load_bridge.sv - self-checking bench for sdram_load_bridge against a transaction-level model
module tb_sdram_load_bridge;

    localparam int DEPTH = 4;
    localparam int AW    = 25;
    localparam int DW    = 16;

    localparam int P_LOAD   = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_READY  = 2;
    localparam int P_RDCMD  = 3;
    localparam int P_RDWAIT = 4;
    localparam int P_ERR    = 5;

    logic          clk50 = 1'b0;
    logic          reset;
    logic          in_we;
    logic [AW-1:0] in_address;
    logic [DW-1:0] in_data;
    logic          in_op_begun;
    logic          in_init_done;
    logic          in_init_error;
    logic [AW-1:0] avm_address;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [1:0]    avm_byteenable;
    logic          avm_read;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;
    logic          avm_readdatavalid;
    logic          play_req;
    logic [AW-1:0] play_addr;
    logic [DW-1:0] play_data;
    logic          play_valid;
    logic          play_busy;
    logic          load_done;
    logic          load_error;
    logic [AW-1:0] words_written;

    always #10 clk50 = ~clk50;

    sdram_load_bridge #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk50(clk50), .reset(reset),
        .in_we(in_we), .in_address(in_address), .in_data(in_data), .in_op_begun(in_op_begun),
        .in_init_done(in_init_done), .in_init_error(in_init_error),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .play_req(play_req), .play_addr(play_addr), .play_data(play_data),
        .play_valid(play_valid), .play_busy(play_busy),
        .load_done(load_done), .load_error(load_error), .words_written(words_written)
    );

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] m_q[$];
    logic [AW+DW-1:0] ld_q[$];
    int               m_phase;
    logic             m_err_tail;
    logic [AW-1:0]    m_written;
    logic [AW-1:0]    m_rd_addr;
    logic             m_pv;
    logic [DW-1:0]    m_pd;
    logic [DW-1:0]    sdram [bit [AW-1:0]];

    int            wr_mode;
    int            wait_cnt;
    int            rdv_delay;
    int            rd_cd;
    logic          pr_pending;
    logic [AW-1:0] pr_addr;
    int            n_begun;
    int            n_rdcmd;
    int            n_pv;
    int            cyc;
    int            t_req;
    int            t_pv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        if (sdram.exists(a)) return sdram[a];
        return 16'h5A5A;
    endfunction

    task automatic cycle();
        int            cnt;
        logic          beg;
        logic          wr_en;
        logic          exp_w;
        logic          exp_r;
        logic          acc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk50);
        cnt   = m_q.size();
        beg   = in_we && (m_phase == P_LOAD) && (cnt < DEPTH);
        wr_en = (m_phase == P_LOAD) || (m_phase == P_DRAIN) || ((m_phase == P_ERR) && m_err_tail);
        exp_w = wr_en && (cnt > 0);
        exp_r = (m_phase == P_RDCMD);
        acc   = exp_w && !avm_waitrequest;
        ea    = exp_w ? m_q[0][AW+DW-1:DW] : (exp_r ? m_rd_addr : '0);
        ed    = exp_w ? m_q[0][DW-1:0] : '0;

        chk("in_op_begun", 64'(in_op_begun), 64'(beg));
        chk("avm_write", 64'(avm_write), 64'(exp_w));
        chk("avm_read", 64'(avm_read), 64'(exp_r));
        chk("avm_address", 64'(avm_address), 64'(ea));
        chk("avm_writedata", 64'(avm_writedata), 64'(ed));
        chk("avm_byteenable", 64'(avm_byteenable), (exp_w || exp_r) ? 64'd3 : 64'd0);
        chk("play_valid", 64'(play_valid), 64'(m_pv));
        chk("play_data", 64'(play_data), 64'(m_pd));
        chk("play_busy", 64'(play_busy), 64'(m_phase != P_READY));
        chk("load_done", 64'(load_done),
            64'((m_phase == P_READY) || (m_phase == P_RDCMD) || (m_phase == P_RDWAIT)));
        chk("load_error", 64'(load_error), 64'(m_phase == P_ERR));
        chk("words_written", 64'(words_written), 64'(m_written));

        if (in_op_begun === 1'b1) n_begun++;
        if (avm_read === 1'b1 && avm_waitrequest === 1'b0) n_rdcmd++;
        if (play_valid === 1'b1) begin
            n_pv++;
            t_pv = cyc;
        end

        if (reset) begin
            m_q.delete();
            m_phase    = P_LOAD;
            m_err_tail = 1'b0;
            m_written  = '0;
            m_rd_addr  = '0;
            m_pv       = 1'b0;
            m_pd       = '0;
        end else begin
            m_pv = 1'b0;
            if (acc) begin
                sdram[m_q[0][AW+DW-1:DW]] = m_q[0][DW-1:0];
                void'(m_q.pop_front());
                m_written++;
            end
            if (beg) begin
                m_q.push_back({in_address, in_data});
                void'(ld_q.pop_front());
            end
            case (m_phase)
                P_LOAD, P_DRAIN: begin
                    if (in_init_error) begin
                        m_phase    = P_ERR;
                        m_err_tail = exp_w && avm_waitrequest;
                    end else if (m_phase == P_LOAD && in_init_done) begin
                        m_phase = P_DRAIN;
                    end else if (m_phase == P_DRAIN && cnt == 0) begin
                        m_phase = P_READY;
                    end
                end
                P_READY: begin
                    if (play_req) begin
                        m_rd_addr = play_addr;
                        m_phase   = P_RDCMD;
                    end
                end
                P_RDCMD: begin
                    if (!avm_waitrequest) begin
                        m_phase = P_RDWAIT;
                        rd_cd   = rdv_delay;
                    end
                end
                P_RDWAIT: begin
                    if (avm_readdatavalid) begin
                        m_pd    = avm_readdata;
                        m_pv    = 1'b1;
                        m_phase = P_READY;
                    end
                end
                default: begin
                    if (acc) m_err_tail = 1'b0;
                end
            endcase
        end

        @(posedge clk50);
        #1;
        cyc++;
        in_we = (ld_q.size() > 0);
        {in_address, in_data} = (ld_q.size() > 0) ? ld_q[0] : '0;
        play_req  = pr_pending;
        play_addr = pr_addr;
        if (pr_pending) t_req = cyc;
        pr_pending = 1'b0;
        if (m_phase == P_RDCMD && wait_cnt > 0) begin
            avm_waitrequest = 1'b1;
            wait_cnt--;
        end else if (wr_mode == 0) begin
            avm_waitrequest = 1'b0;
        end else if (wr_mode == 1) begin
            avm_waitrequest = 1'b1;
        end else begin
            avm_waitrequest = 1'($urandom_range(0, 1));
        end
        avm_readdatavalid = 1'b0;
        avm_readdata      = DW'($urandom);
        if (m_phase == P_RDWAIT) begin
            if (rd_cd > 0) begin
                rd_cd--;
            end else begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem_rd(m_rd_addr);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic probe();
        #2;
    endtask

    task automatic run_ld_empty(input int limit);
        int i;
        i = 0;
        while (ld_q.size() > 0 && i < limit) begin
            cycle();
            i++;
        end
        chk("loader_timeout", 64'(i < limit), 64'd1);
    endtask

    task automatic run_to_ready(input int limit);
        int i;
        i = 0;
        while (m_phase != P_READY && i < limit) begin
            cycle();
            i++;
        end
        chk("ready_timeout", 64'(i < limit), 64'd1);
    endtask

    task automatic reset_dut();
        reset         = 1'b1;
        in_init_done  = 1'b0;
        in_init_error = 1'b0;
        ld_q.delete();
        wait_cnt   = 0;
        pr_pending = 1'b0;
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        reset = 1'b1; in_we = 1'b0; in_address = '0; in_data = '0;
        in_init_done = 1'b0; in_init_error = 1'b0;
        avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        play_req = 1'b0; play_addr = '0;
        m_phase = P_LOAD; m_err_tail = 1'b0; m_written = '0; m_rd_addr = '0;
        m_pv = 1'b0; m_pd = '0;
        wr_mode = 0; wait_cnt = 0; rdv_delay = 0; rd_cd = 0;
        pr_pending = 1'b0; pr_addr = '0;
        n_begun = 0; n_rdcmd = 0; n_pv = 0; cyc = 0; t_req = 0; t_pv = -100;

        run(2);
        reset = 1'b0;
        probe();
        chk("rst_play_busy", 64'(play_busy), 64'd1);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_words", 64'(words_written), 64'd0);
        chk("rst_avm_write", 64'(avm_write), 64'd0);

        // three words, no stall
        for (int i = 0; i < 3; i++) ld_q.push_back({AW'(i), DW'(16'hA000 + i)});
        n_begun = 0;
        run(8);
        probe();
        chk("t1_words", 64'(words_written), 64'd3);
        chk("t1_begun", 64'(n_begun), 64'd3);

        // stalled bus while six words arrive: buffer fills at DEPTH
        wr_mode = 1;
        n_begun = 0;
        for (int i = 0; i < 6; i++) ld_q.push_back({AW'(25'h100 + i), DW'($urandom)});
        run(20);
        chk("t2_fill_begun", 64'(n_begun), 64'(DEPTH));
        chk("t2_words_stalled", 64'(words_written), 64'd3);
        wr_mode = 0;
        run_ld_empty(50);
        run(6);
        probe();
        chk("t2_words", 64'(words_written), 64'd9);
        chk("t2_begun", 64'(n_begun), 64'd6);

        // random stalls with random words
        wr_mode = 2;
        for (int i = 0; i < 20; i++) ld_q.push_back({AW'($urandom_range(25'h1000, 25'h1FFFFFF)), DW'($urandom)});
        run_ld_empty(400);
        wr_mode = 0;
        run(8);
        probe();
        chk("rand_words", 64'(words_written), 64'd29);

        // two words buffered, then loading finishes
        wr_mode = 1;
        for (int i = 0; i < 2; i++) ld_q.push_back({AW'(25'h300 + i), DW'($urandom)});
        run(4);
        in_init_done = 1'b1;
        ld_q.push_back({AW'(25'h3FF), DW'(16'h1234)});
        n_begun = 0;
        run(3);
        chk("t3_drain_begun", 64'(n_begun), 64'd0);
        probe();
        chk("t3_not_done", 64'(load_done), 64'd0);
        wr_mode = 0;
        run_to_ready(50);
        ld_q.delete();
        probe();
        chk("t3_load_done", 64'(load_done), 64'd1);
        chk("t3_words", 64'(words_written), 64'd31);

        // read with two-cycle stall and delayed data; second request while busy
        sdram[25'h10] = 16'hBEEF;
        pr_addr = 25'h10; pr_pending = 1'b1; wait_cnt = 2; rdv_delay = 2;
        n_rdcmd = 0; n_pv = 0;
        run(2);
        pr_addr = 25'h20; pr_pending = 1'b1;
        run(12);
        probe();
        chk("t4_read_cmds", 64'(n_rdcmd), 64'd1);
        chk("t4_valid_pulses", 64'(n_pv), 64'd1);
        chk("t4_play_data", 64'(play_data), 64'h BEEF);
        chk("t4_idle_busy", 64'(play_busy), 64'd0);

        // minimum latency read
        rdv_delay = 0; wait_cnt = 0;
        pr_addr = 25'h1; pr_pending = 1'b1;
        run(6);
        chk("lat_cycles", 64'(t_pv - t_req), 64'd3);
        chk("lat_data", 64'(play_data), 64'h A001);

        // random reads of known words
        for (int k = 0; k < 4; k++) begin
            ra = AW'($urandom_range(0, 2));
            rdv_delay = $urandom_range(0, 3);
            wait_cnt  = $urandom_range(0, 2);
            pr_addr = ra; pr_pending = 1'b1;
            run(12);
            chk("rand_read_data", 64'(play_data), 64'(16'hA000 + ra));
        end

        // loader error while a write is stalled on the bus
        reset_dut();
        wr_mode = 1;
        for (int i = 0; i < 3; i++) ld_q.push_back({AW'(25'h200 + i), DW'($urandom)});
        run(5);
        in_init_error = 1'b1;
        run(3);
        wr_mode = 0;
        run(10);
        probe();
        chk("t5_words", 64'(words_written), 64'd1);
        chk("t5_load_error", 64'(load_error), 64'd1);
        chk("t5_load_done", 64'(load_done), 64'd0);
        chk("t5_write_stopped", 64'(avm_write), 64'd0);
        ld_q.delete();
        in_init_error = 1'b0;
        run(2);
        probe();
        chk("t5_sticky", 64'(load_error), 64'd1);

        // reset while a read command is stalled
        reset_dut();
        for (int i = 0; i < 2; i++) ld_q.push_back({AW'(25'h400 + i), DW'($urandom)});
        run(5);
        in_init_done = 1'b1;
        run(4);
        probe();
        chk("t6_ready", 64'(load_done), 64'd1);
        pr_addr = 25'h30; pr_pending = 1'b1; wait_cnt = 10;
        run(2);
        probe();
        chk("t6_rd_cmd", 64'(avm_read), 64'd1);
        reset = 1'b1;
        in_init_done = 1'b0;
        run(1);
        reset = 1'b0;
        wait_cnt = 0;
        probe();
        chk("t6_avm_read", 64'(avm_read), 64'd0);
        chk("t6_play_busy", 64'(play_busy), 64'd1);
        chk("t6_words", 64'(words_written), 64'd0);
        chk("t6_load_done", 64'(load_done), 64'd0);
        run(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_load_bridge.md
Name: sdram_load_bridge

Overview:
Downstream stage of the SD-card RAM loader. Accepts the loader's word-write handshake (we/address/data → op_begun) and buffers words in a small FIFO. Drains them as Avalon-MM writes to the SDRAM controller. After loading completes, it serves single-word reads to the audio playback engine over the same Avalon master.

Parameters:
FIFO_DEPTH, 4, write-buffer entries; must be a power of two ≥ 2
ADDR_W, 25, word-address width (32M × 16 SDRAM)
DATA_W, 16, data word width

Ports:
clk50  in  1  system clock
reset  in  1  reset
in_we  in  1  loader write request; held high until in_op_begun
in_address  in  ADDR_W  loader word address
in_data  in  DATA_W  loader word
in_op_begun  out  1  write accepted this cycle (combinational)
in_init_done  in  1  loader finished all words (level)
in_init_error  in  1  loader SD init failure (level)
avm_address  out  ADDR_W  Avalon word address
avm_write  out  1  Avalon write strobe
avm_writedata  out  DATA_W  Avalon write data
avm_byteenable  out  2  always 2'b11 while a command is presented, else 0
avm_read  out  1  Avalon read strobe
avm_readdata  in  DATA_W  Avalon read data
avm_waitrequest  in  1  Avalon stall
avm_readdatavalid  in  1  Avalon read data valid
play_req  in  1  playback read request (one-cycle pulse)
play_addr  in  ADDR_W  playback word address
play_data  out  DATA_W  returned sample, held until the next valid
play_valid  out  1  one-cycle pulse, play_data valid
play_busy  out  1  high = play_req ignored
load_done  out  1  all words written to SDRAM, reads enabled
load_error  out  1  sticky error
words_written  out  ADDR_W  count of completed Avalon writes

Behaviour:
- Reset: reset is synchronous and active-high; the clock is clk50. Reset empties the FIFO, enters LOAD, and clears all outputs/counters to 0, except play_busy = 1. Reset mid-transaction drops any Avalon command immediately; no completion is tracked.
- States: LOAD, DRAIN, READY, RD_CMD, RD_WAIT, ERROR.
- in_op_begun = in_we & !full & (state == LOAD). The FIFO pushes {in_address, in_data} in the same cycle. There is no push in any other state.
- Write engine (LOAD/DRAIN/ERROR):
  - When the FIFO is non-empty, present the head on avm_address/avm_writedata with avm_write = 1.
  - Hold the head stable while avm_waitrequest = 1.
  - Pop when avm_write & !avm_waitrequest; words_written increments that cycle.
  - Back-to-back writes are allowed with no idle cycle.
- Simultaneous push and pop when full: the push is refused (full is evaluated before the pop). When not full, push and pop in the same cycle are allowed and occupancy is unchanged.
- Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits. full = MSBs differ and LSBs equal; empty = pointers equal.
- Transitions:
  - LOAD → DRAIN when in_init_done = 1. A push in that same cycle is still accepted.
  - DRAIN → READY when the FIFO is empty and no write is pending.
  - LOAD/DRAIN → ERROR when in_init_error = 1. ERROR finishes any presented write, then stops popping and never leaves until reset.
- load_error = 1 in ERROR. load_done = 1 in READY, RD_CMD and RD_WAIT.
- Reads:
  - In READY, play_busy = 0. play_req → latch play_addr, go to RD_CMD; play_busy = 1 from the next cycle.
  - RD_CMD: avm_read = 1 and avm_address = latched address until !avm_waitrequest, then go to RD_WAIT.
  - RD_WAIT: on avm_readdatavalid, register play_data, pulse play_valid for exactly 1 cycle, return to READY.
  - Only one read is outstanding at a time. play_req is ignored while play_busy = 1.
  - Minimum latency from play_req to play_valid: 3 cycles (waitrequest = 0, readdatavalid the cycle after the command).
- avm_read and avm_write are never high in the same cycle.

Test Plan:
1. Push 3 words (addr 0..2, data 16'hA000..A002), waitrequest = 0 → three writes in order, words_written = 3, in_op_begun pulses once per word.
2. Hold waitrequest = 1 for 20 cycles while the loader pushes 6 words → FIFO fills at 4, in_op_begun stays low with in_we high, address/data stay stable; on release all 6 complete in order (pointer wrap exercised).
3. Assert in_init_done with 2 words buffered → DRAIN, load_done rises one cycle after the last write accepts; in_we in DRAIN gives in_op_begun = 0.
4. In READY, play_req with addr 25'h000010, waitrequest 2 cycles, readdatavalid 3 cycles later with 16'hBEEF → one avm_read command, play_valid for 1 cycle with play_data = 16'hBEEF; a play_req while busy is ignored (no second read).
5. Assert in_init_error with 1 word presented and waitrequest = 1 → that write completes when waitrequest drops, no further pops, load_error = 1 sticky, load_done = 0.
6. Assert reset during RD_CMD → next cycle avm_read = 0, play_busy = 1, words_written = 0, state LOAD.
